pe_rs_conv: RTL and testbench
=============================

// Module: pe_rs_conv
// PURPOSE
// Functional row-stationary PE for the PE array; replaces the debug stub at each array slot.
// Holds S*q*p filter weights stationary and slides an S*q ifmap window over F output columns.
// Per column it computes p partial sums (one MAC/cycle), adds p incoming ipsums, and streams p opsums.
// PARAMETERS
// IFMAP_SPAD_SIZE   12   ifmap window entries; must be >= S*q
// FILTER_SPAD_SIZE  224  weight entries; must be >= S*q*p
// PSUM_SPAD_SIZE    24   psum accumulators; must be >= p
// IFMAP_DATA_SIZE   8    signed ifmap width
// FILTER_DATA_SIZE  8    signed weight width
// PSUM_DATA_SIZE    16   signed psum/opsum width (two's-complement wrap)
// CONFIG_Q_BIT/P/U/S/F  2/5/4/4/8  config field widths
// PORTS
// clk            in   1    clock
// rst            in   1    synchronous, active-high reset
// set_info       in   1    latch config_* and start full pass (IDLE only)
// enable         in   1    start pass reusing stored weights (IDLE only)
// config_q/p/U/S/F in  CONFIG_*_BIT  q=config_q+1, p=config_p+1, stride U, filter width S, output columns F
// filter         in   FILTER_DATA_SIZE   weight; filter_enable in 1 valid; filter_ready out 1
// ifmap          in   IFMAP_DATA_SIZE    activation; ifmap_enable in 1; ifmap_ready out 1
// ipsum          in   PSUM_DATA_SIZE     incoming psum; ipsum_enable in 1; ipsum_ready out 1
// opsum          out  PSUM_DATA_SIZE     outgoing psum; opsum_enable out 1 valid; opsum_ready in 1
// busy out 1 not IDLE; done out 1 one-cycle pulse after last opsum; cfg_err out 1 sticky bad config
// BEHAVIOUR
// - Transfer = X_enable & X_ready at posedge clk. Reset: state IDLE, all readies/opsum_enable/busy/done 0,
//   opsum 0, cfg_err 0, counters 0; spad contents undefined. rst mid-pass aborts; no further output.
// - States: IDLE -> LD_FILT -> LD_IFM -> MAC -> DRAIN -> (LD_IFM | IDLE).
// - IDLE: set_info legal -> latch config, cfg_err<=0, LD_FILT. Illegal (S=0,U=0,F=0,U>S, S*q>IFMAP_SPAD,
//   S*q*p>FILTER_SPAD, p>PSUM_SPAD) -> cfg_err<=1, stay IDLE. enable with valid stored weights -> LD_IFM
//   (first-column load); enable with none stored or cfg_err=1 ignored. set_info wins if both high.
//   set_info/enable outside IDLE ignored.
// - LD_FILT: filter_ready=1; accept S*q*p weights, index t*p+k, t=s*q+c (s outer, c, k inner).
// - LD_IFM: ifmap_ready=1; column 0 loads S*q values, later columns U*q values; order x outer, c inner.
//   Circular window; base advances U*q (mod S*q) per column; new values overwrite oldest entries.
// - MAC: one cycle per (t,k), t outer: psum[k] = (t==0 ? 0 : psum[k]) + win[(base+t) mod S*q]*w[t*p+k].
//   Product sign-extended, sum truncated to PSUM_DATA_SIZE. Latency S*q*p cycles, no stalls.
// - DRAIN: ipsum_ready = ~opsum_enable | opsum_ready; on ipsum transfer for index k:
//   opsum<=psum[k]+ipsum (wrap), opsum_enable<=1, k++. opsum held stable while opsum_enable & ~opsum_ready.
//   opsum_enable falls when last accepted and no new ipsum. Order k=0..p-1.
// - After p-th opsum accepted: col++; col==F -> done=1 one cycle, IDLE; else LD_IFM.
// - Weights persist across passes until next set_info or rst; ifmap window cleared per pass (col=0).
// STRUCTURE
// - pe_pkg: state enum, config field widths, config-legality function.
// - pe_spad sub-module (param DEPTH, WIDTH; sync write, comb read), instanced for ifmap, filter, psum.
// - Top: FSM, t/k/col/base counters, MAC datapath, opsum output register.
// TESTING
// - 1D: q=1,p=1,S=3,U=1,F=2; w=1,2,3; ifmap 1,2,3,4; ipsum 10,20 -> opsum 24,40, done pulse.
// - Multi: q=2,p=2,S=1,U=1,F=1; w=1,2,3,4; ifmap 5,6; ipsum 0,0 -> opsum 23,34.
// - Stride: q=1,p=1,S=2,U=2,F=2; w=1,1; ifmap 1,2,3,4; ipsum 0,0 -> opsum 3,7; 4 ifmap transfers only.
// - Wrap/backpressure: S=2,q=1,p=1,F=1; w=-128,-128; ifmap -128,-128; ipsum 0; opsum_ready low 5 cycles
//   -> opsum 16'h8000 held stable, ipsum_ready 0 until accepted.
// - Config/reuse: config_S=0 -> cfg_err=1, filter_ready 0; legal set_info, then enable -> reuse weights,
//   no filter transfers, identical opsums.
// - rst asserted in MAC -> next cycle IDLE, busy=0, opsum_enable=0; new set_info pass correct.

Source files
------------

// File: rtl/pe_pkg.sv
// Shared definitions for the row-stationary PE: FSM state codes, config field
// widths and the configuration legality check.
package pe_pkg;

  localparam int CFG_Q_W = 2;
  localparam int CFG_P_W = 5;
  localparam int CFG_U_W = 4;
  localparam int CFG_S_W = 4;
  localparam int CFG_F_W = 8;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_LD_FILT = 3'd1;
  localparam logic [2:0] ST_LD_IFM  = 3'd2;
  localparam logic [2:0] ST_MAC     = 3'd3;
  localparam logic [2:0] ST_DRAIN   = 3'd4;

  // q and p arrive already decoded (field + 1); spad sizes come from the instance.
  function automatic logic cfg_legal(input int q, input int p, input int u, input int s,
                                     input int f, input int ifm_sz, input int fil_sz,
                                     input int ps_sz);
    return (s != 0) && (u != 0) && (f != 0) && (u <= s) &&
           (s * q <= ifm_sz) && (s * q * p <= fil_sz) && (p <= ps_sz);
  endfunction

endpackage

// File: rtl/pe_spad.sv
// Scratchpad with synchronous write and combinational read.
module pe_spad #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/pe_rs_conv.sv
// Row-stationary PE: stationary weights, circular ifmap window, p partial sums
// per output column, merged with incoming psums and streamed out.
module pe_rs_conv
  import pe_pkg::*;
#(
  parameter int IFMAP_SPAD_SIZE  = 12,
  parameter int FILTER_SPAD_SIZE = 224,
  parameter int PSUM_SPAD_SIZE   = 24,
  parameter int IFMAP_DATA_SIZE  = 8,
  parameter int FILTER_DATA_SIZE = 8,
  parameter int PSUM_DATA_SIZE   = 16,
  parameter int CONFIG_Q_BIT     = CFG_Q_W,
  parameter int CONFIG_P_BIT     = CFG_P_W,
  parameter int CONFIG_U_BIT     = CFG_U_W,
  parameter int CONFIG_S_BIT     = CFG_S_W,
  parameter int CONFIG_F_BIT     = CFG_F_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        set_info,
  input  logic                        enable,
  input  logic [CONFIG_Q_BIT-1:0]     config_q,
  input  logic [CONFIG_P_BIT-1:0]     config_p,
  input  logic [CONFIG_U_BIT-1:0]     config_U,
  input  logic [CONFIG_S_BIT-1:0]     config_S,
  input  logic [CONFIG_F_BIT-1:0]     config_F,
  input  logic [FILTER_DATA_SIZE-1:0] filter,
  input  logic                        filter_enable,
  output logic                        filter_ready,
  input  logic [IFMAP_DATA_SIZE-1:0]  ifmap,
  input  logic                        ifmap_enable,
  output logic                        ifmap_ready,
  input  logic [PSUM_DATA_SIZE-1:0]   ipsum,
  input  logic                        ipsum_enable,
  output logic                        ipsum_ready,
  output logic [PSUM_DATA_SIZE-1:0]   opsum,
  output logic                        opsum_enable,
  input  logic                        opsum_ready,
  output logic                        busy,
  output logic                        done,
  output logic                        cfg_err
);

  localparam int IA_W = (IFMAP_SPAD_SIZE > 1) ? $clog2(IFMAP_SPAD_SIZE) : 1;
  localparam int FA_W = (FILTER_SPAD_SIZE > 1) ? $clog2(FILTER_SPAD_SIZE) : 1;
  localparam int PA_W = (PSUM_SPAD_SIZE > 1) ? $clog2(PSUM_SPAD_SIZE) : 1;

  function automatic logic signed [PSUM_DATA_SIZE-1:0] mac_wrap(
      input logic signed [PSUM_DATA_SIZE-1:0]   acc,
      input logic signed [IFMAP_DATA_SIZE-1:0]  a,
      input logic signed [FILTER_DATA_SIZE-1:0] b);
    logic signed [PSUM_DATA_SIZE-1:0] ea;
    logic signed [PSUM_DATA_SIZE-1:0] eb;
    ea = PSUM_DATA_SIZE'(a);
    eb = PSUM_DATA_SIZE'(b);
    return acc + ea * eb;
  endfunction

  function automatic logic signed [PSUM_DATA_SIZE-1:0] add_wrap(
      input logic signed [PSUM_DATA_SIZE-1:0] a,
      input logic signed [PSUM_DATA_SIZE-1:0] b);
    return a + b;
  endfunction

  logic [2:0]  state_q, state_d;
  logic [15:0] p_q, p_d, uq_q, uq_d, sq_q, sq_d, sqp_q, sqp_d, f_q, f_d;
  logic [15:0] cnt_q, cnt_d, t_q, t_d, k_q, k_d, mac_q, mac_d;
  logic [15:0] col_q, col_d, base_q, base_d;
  logic        wts_vld_q, wts_vld_d, cfg_err_q, cfg_err_d;
  logic        done_q, done_d, oen_q, oen_d;
  logic signed [PSUM_DATA_SIZE-1:0] opsum_q, opsum_d;

  logic [15:0] q_in, p_in, u_in, s_in, f_in;
  logic        cfg_ok;
  logic        filt_fire, ifm_fire, ips_fire;
  logic [15:0] ld_tgt, wr_sum, wr_idx, rd_sum, rd_idx, base_adv, base_nxt;
  logic [IFMAP_DATA_SIZE-1:0]  ifm_rd;
  logic [FILTER_DATA_SIZE-1:0] fil_rd;
  logic [PSUM_DATA_SIZE-1:0]   psum_rd;
  logic signed [PSUM_DATA_SIZE-1:0] mac_res;

  assign q_in = 16'(config_q) + 16'd1;
  assign p_in = 16'(config_p) + 16'd1;
  assign u_in = 16'(config_U);
  assign s_in = 16'(config_S);
  assign f_in = 16'(config_F);
  assign cfg_ok = cfg_legal(int'(q_in), int'(p_in), int'(u_in), int'(s_in), int'(f_in),
                            IFMAP_SPAD_SIZE, FILTER_SPAD_SIZE, PSUM_SPAD_SIZE);

  assign filter_ready = (state_q == ST_LD_FILT);
  assign ifmap_ready  = (state_q == ST_LD_IFM);
  assign ipsum_ready  = (state_q == ST_DRAIN) && (k_q < p_q) && (!oen_q || opsum_ready);
  assign filt_fire    = filter_enable && filter_ready;
  assign ifm_fire     = ifmap_enable && ifmap_ready;
  assign ips_fire     = ipsum_enable && ipsum_ready;

  // New ifmap values land on the oldest slots, which start at the current base.
  assign ld_tgt   = (col_q == 16'd0) ? sq_q : uq_q;
  assign wr_sum   = base_q + cnt_q;
  assign wr_idx   = (wr_sum >= sq_q) ? wr_sum - sq_q : wr_sum;
  assign rd_sum   = base_q + t_q;
  assign rd_idx   = (rd_sum >= sq_q) ? rd_sum - sq_q : rd_sum;
  assign base_adv = base_q + uq_q;
  assign base_nxt = (base_adv >= sq_q) ? base_adv - sq_q : base_adv;

  pe_spad #(.DEPTH(IFMAP_SPAD_SIZE), .WIDTH(IFMAP_DATA_SIZE)) u_ifm_spad (
    .clk(clk), .we_i(ifm_fire), .waddr_i(IA_W'(wr_idx)), .wdata_i(ifmap),
    .raddr_i(IA_W'(rd_idx)), .rdata_o(ifm_rd));

  pe_spad #(.DEPTH(FILTER_SPAD_SIZE), .WIDTH(FILTER_DATA_SIZE)) u_fil_spad (
    .clk(clk), .we_i(filt_fire), .waddr_i(FA_W'(cnt_q)), .wdata_i(filter),
    .raddr_i(FA_W'(mac_q)), .rdata_o(fil_rd));

  pe_spad #(.DEPTH(PSUM_SPAD_SIZE), .WIDTH(PSUM_DATA_SIZE)) u_psum_spad (
    .clk(clk), .we_i(state_q == ST_MAC), .waddr_i(PA_W'(k_q)), .wdata_i(mac_res),
    .raddr_i(PA_W'(k_q)), .rdata_o(psum_rd));

  assign mac_res = mac_wrap((t_q == 16'd0) ? '0 : $signed(psum_rd),
                            $signed(ifm_rd), $signed(fil_rd));

  always_comb begin
    state_d   = state_q;
    p_d       = p_q;
    uq_d      = uq_q;
    sq_d      = sq_q;
    sqp_d     = sqp_q;
    f_d       = f_q;
    cnt_d     = cnt_q;
    t_d       = t_q;
    k_d       = k_q;
    mac_d     = mac_q;
    col_d     = col_q;
    base_d    = base_q;
    wts_vld_d = wts_vld_q;
    cfg_err_d = cfg_err_q;
    done_d    = 1'b0;
    oen_d     = oen_q;
    opsum_d   = opsum_q;
    case (state_q)
      ST_IDLE: begin
        if (set_info) begin
          if (cfg_ok) begin
            p_d       = p_in;
            uq_d      = u_in * q_in;
            sq_d      = s_in * q_in;
            sqp_d     = s_in * q_in * p_in;
            f_d       = f_in;
            cfg_err_d = 1'b0;
            wts_vld_d = 1'b0;
            cnt_d     = '0;
            state_d   = ST_LD_FILT;
          end else begin
            cfg_err_d = 1'b1;
          end
        end else if (enable && wts_vld_q && !cfg_err_q) begin
          cnt_d   = '0;
          col_d   = '0;
          base_d  = '0;
          state_d = ST_LD_IFM;
        end
      end
      ST_LD_FILT: begin
        if (filt_fire) begin
          if (cnt_q == sqp_q - 16'd1) begin
            wts_vld_d = 1'b1;
            cnt_d     = '0;
            col_d     = '0;
            base_d    = '0;
            state_d   = ST_LD_IFM;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      ST_LD_IFM: begin
        if (ifm_fire) begin
          if (cnt_q == ld_tgt - 16'd1) begin
            if (col_q != 16'd0) base_d = base_nxt;
            t_d     = '0;
            k_d     = '0;
            mac_d   = '0;
            state_d = ST_MAC;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      ST_MAC: begin
        mac_d = mac_q + 16'd1;
        if (k_q == p_q - 16'd1) begin
          k_d = '0;
          t_d = t_q + 16'd1;
        end else begin
          k_d = k_q + 16'd1;
        end
        if (mac_q == sqp_q - 16'd1) begin
          k_d     = '0;
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (ips_fire) begin
          opsum_d = add_wrap($signed(psum_rd), $signed(ipsum));
          oen_d   = 1'b1;
          k_d     = k_q + 16'd1;
        end else if (oen_q && opsum_ready) begin
          oen_d = 1'b0;
          if (k_q == p_q) begin
            col_d = col_q + 16'd1;
            cnt_d = '0;
            if (col_q + 16'd1 == f_q) begin
              done_d  = 1'b1;
              state_d = ST_IDLE;
            end else begin
              state_d = ST_LD_IFM;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      t_q       <= '0;
      k_q       <= '0;
      mac_q     <= '0;
      col_q     <= '0;
      base_q    <= '0;
      wts_vld_q <= 1'b0;
      cfg_err_q <= 1'b0;
      done_q    <= 1'b0;
      oen_q     <= 1'b0;
      opsum_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      t_q       <= t_d;
      k_q       <= k_d;
      mac_q     <= mac_d;
      col_q     <= col_d;
      base_q    <= base_d;
      wts_vld_q <= wts_vld_d;
      cfg_err_q <= cfg_err_d;
      done_q    <= done_d;
      oen_q     <= oen_d;
      opsum_q   <= opsum_d;
    end
  end

  // Latched configuration is only meaningful while wts_vld_q/state say so.
  always_ff @(posedge clk) begin
    p_q   <= p_d;
    uq_q  <= uq_d;
    sq_q  <= sq_d;
    sqp_q <= sqp_d;
    f_q   <= f_d;
  end

  assign opsum        = opsum_q;
  assign opsum_enable = oen_q;
  assign busy         = (state_q != ST_IDLE);
  assign done         = done_q;
  assign cfg_err      = cfg_err_q;

endmodule

// File: tb/tb_pe_rs_conv.sv
// Directed bench for pe_rs_conv: hand-computed opsum vectors, handshake and
// control checks, all through one checking task.
module tb_pe_rs_conv;

  localparam int LIM = 300;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        set_info = 1'b0, enable = 1'b0;
  logic [1:0]  config_q = '0;
  logic [4:0]  config_p = '0;
  logic [3:0]  config_U = '0, config_S = '0;
  logic [7:0]  config_F = '0;
  logic [7:0]  filter = '0, ifmap = '0;
  logic        filter_enable = 1'b0, ifmap_enable = 1'b0, ipsum_enable = 1'b0;
  logic        filter_ready, ifmap_ready, ipsum_ready;
  logic [15:0] ipsum = '0;
  logic [15:0] opsum;
  logic        opsum_enable, opsum_ready = 1'b0;
  logic        busy, done, cfg_err;

  int n_chk = 0, n_fail = 0, n_filt = 0, n_ifm = 0, base_cnt;
  int fv[$], iv[$], pv[$], ev[$];

  always #5 clk = ~clk;

  pe_rs_conv dut (
    .clk(clk), .rst(rst), .set_info(set_info), .enable(enable),
    .config_q(config_q), .config_p(config_p), .config_U(config_U),
    .config_S(config_S), .config_F(config_F),
    .filter(filter), .filter_enable(filter_enable), .filter_ready(filter_ready),
    .ifmap(ifmap), .ifmap_enable(ifmap_enable), .ifmap_ready(ifmap_ready),
    .ipsum(ipsum), .ipsum_enable(ipsum_enable), .ipsum_ready(ipsum_ready),
    .opsum(opsum), .opsum_enable(opsum_enable), .opsum_ready(opsum_ready),
    .busy(busy), .done(done), .cfg_err(cfg_err));

  always @(posedge clk) begin
    if (filter_enable && filter_ready) n_filt <= n_filt + 1;
    if (ifmap_enable && ifmap_ready) n_ifm <= n_ifm + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h expected 'h%0h", tag, got, exp);
    end
  endtask

  task automatic start_cfg(input int q, input int p, input int u, input int s, input int f);
    config_q = 2'(q);
    config_p = 5'(p);
    config_U = 4'(u);
    config_S = 4'(s);
    config_F = 8'(f);
    set_info = 1'b1;
    @(negedge clk);
    set_info = 1'b0;
  endtask

  task automatic put_filt();
    int w;
    if (fv.size() == 0) return;
    foreach (fv[i]) begin
      filter = 8'(fv[i]);
      filter_enable = 1'b1;
      w = 0;
      #2;
      while (!filter_ready && w < LIM) begin @(negedge clk); #2; w++; end
      if (!filter_ready) begin chk("filt_wait", 32'(filter_ready), 1); break; end
      @(negedge clk);
    end
    filter_enable = 1'b0;
  endtask

  task automatic put_ifm();
    int w;
    foreach (iv[i]) begin
      ifmap = 8'(iv[i]);
      ifmap_enable = 1'b1;
      w = 0;
      #2;
      while (!ifmap_ready && w < LIM) begin @(negedge clk); #2; w++; end
      if (!ifmap_ready) begin chk("ifm_wait", 32'(ifmap_ready), 1); break; end
      @(negedge clk);
    end
    ifmap_enable = 1'b0;
  endtask

  task automatic put_ips();
    int w;
    foreach (pv[i]) begin
      ipsum = 16'(pv[i]);
      ipsum_enable = 1'b1;
      w = 0;
      #2;
      while (!ipsum_ready && w < LIM) begin @(negedge clk); #2; w++; end
      if (!ipsum_ready) begin chk("ips_wait", 32'(ipsum_ready), 1); break; end
      @(negedge clk);
    end
    ipsum_enable = 1'b0;
  endtask

  task automatic get_ops(input string nm, input int hold);
    int w;
    foreach (ev[i]) begin
      logic [31:0] exp_v;
      exp_v = ev[i] & 32'hFFFF;
      opsum_ready = (hold == 0);
      w = 0;
      #2;
      while (!opsum_enable && w < LIM) begin @(negedge clk); #2; w++; end
      if (!opsum_enable) begin chk({nm, "_ops_wait"}, 32'(opsum_enable), 1); return; end
      for (int h = 0; h < hold; h++) begin
        chk({nm, "_hold_val"}, 32'(opsum), exp_v);
        chk({nm, "_hold_ipsum_rdy"}, 32'(ipsum_ready), 0);
        @(negedge clk);
        #2;
      end
      opsum_ready = 1'b1;
      chk($sformatf("%s_opsum%0d", nm, i), 32'(opsum), exp_v);
      @(negedge clk);
    end
  endtask

  task automatic run_pass(input string nm, input int hold);
    fork
      put_filt();
      put_ifm();
      put_ips();
      get_ops(nm, hold);
    join
    #2;
    chk({nm, "_done"}, 32'(done), 1);
    chk({nm, "_busy_end"}, 32'(busy), 0);
    @(negedge clk);
    #2;
    chk({nm, "_done_low"}, 32'(done), 0);
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #2;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_oen", 32'(opsum_enable), 0);
    chk("rst_opsum", 32'(opsum), 0);
    chk("rst_cfg_err", 32'(cfg_err), 0);
    chk("rst_rdy", {29'd0, filter_ready, ifmap_ready, ipsum_ready}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // S = 0 is rejected; stays idle and enable without weights is ignored
    start_cfg(0, 0, 1, 0, 1);
    #2;
    chk("bad_cfg_err", 32'(cfg_err), 1);
    chk("bad_cfg_busy", 32'(busy), 0);
    chk("bad_cfg_frdy", 32'(filter_ready), 0);
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    #2;
    chk("bad_cfg_enable", 32'(busy), 0);
    @(negedge clk);

    // 1D: windows (1,2,3),(2,3,4) . (1,2,3) = 14, 20; plus 10, 20
    fv = '{1, 2, 3}; iv = '{1, 2, 3, 4}; pv = '{10, 20}; ev = '{24, 40};
    start_cfg(0, 0, 1, 3, 2);
    run_pass("1d", 0);

    // q=2, p=2: psum0 = 5*1 + 6*3, psum1 = 5*2 + 6*4
    fv = '{1, 2, 3, 4}; iv = '{5, 6}; pv = '{0, 0}; ev = '{23, 34};
    start_cfg(1, 1, 1, 1, 1);
    #2;
    chk("multi_cfg_err", 32'(cfg_err), 0);
    chk("multi_busy", 32'(busy), 1);
    @(negedge clk);
    run_pass("multi", 0);

    // Reuse stored weights; an offered filter must never be taken
    base_cnt = n_filt;
    filter = 8'd99;
    filter_enable = 1'b1;
    fv.delete();
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    run_pass("reuse", 0);
    filter_enable = 1'b0;
    chk("reuse_filt_xfers", 32'(n_filt - base_cnt), 0);

    // Stride 2: windows (1,2),(3,4) with unit weights
    base_cnt = n_ifm;
    fv = '{1, 1}; iv = '{1, 2, 3, 4}; pv = '{0, 0}; ev = '{3, 7};
    start_cfg(0, 0, 2, 2, 2);
    run_pass("stride", 0);
    chk("stride_ifm_xfers", 32'(n_ifm - base_cnt), 4);

    // 2 * (-128 * -128) = 32768 wraps to 16'h8000; held under backpressure
    fv = '{-128, -128}; iv = '{-128, -128}; pv = '{0}; ev = '{32768};
    start_cfg(0, 0, 1, 2, 1);
    run_pass("wrap", 5);

    // Reset while computing aborts the pass
    fv = '{1, 2, 3}; iv = '{1, 2, 3};
    start_cfg(0, 0, 1, 3, 2);
    fork
      put_filt();
      put_ifm();
    join
    #2;
    chk("mac_busy", 32'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    #2;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_oen", 32'(opsum_enable), 0);
    chk("abort_ifm_rdy", 32'(ifmap_ready), 0);
    rst = 1'b0;
    @(negedge clk);

    fv = '{1, 2, 3}; iv = '{1, 2, 3, 4}; pv = '{10, 20}; ev = '{24, 40};
    start_cfg(0, 0, 1, 3, 2);
    run_pass("after_rst", 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
